// File: rtl/rf_stream_ctrl.sv
// rf_stream_ctrl: sweeps the 8-entry register file, either filling it
// from a valid/ready input stream (LOAD) or dumping it to an output stream.
module rf_stream_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] WR_addr,
  output logic [DW-1:0] WR_data,
  output logic          WE,
  output logic [AW-1:0] RA_addr,
  input  logic [DW-1:0] RA_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_d;
  logic            last;
  logic [DW-1:0]   out_data_q;
  logic            busy_q;
  logic            done_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            rd_en_q;

  assign ptr_d = ptr_q + AW'(1);
  assign last  = (ptr_q == AW'(NREG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ptr_q  <= '0;
            busy_q <= 1'b1;
            if (mode) begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ptr_q <= ptr_d;
            if (last) begin
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          out_data_q  <= RA_data;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            ptr_q       <= ptr_d;
            out_valid_q <= 1'b0;
            if (last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              rd_en_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          rd_en_q     <= 1'b0;
        end
      endcase
    end
  end

  // Write port is gated by the registered ready so reset kills WE at once.
  assign WE       = in_valid & in_ready_q;
  assign WR_addr  = in_ready_q ? ptr_q : '0;
  assign WR_data  = in_ready_q ? in_data : '0;
  assign RA_addr  = rd_en_q ? ptr_q : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
